rom_checksum_ctrl: RTL

Clocked sequencer that walks the 16-word ROM, accumulates words 0..14, compares the sum against the checksum in word 15, writes the sum into one word of the 4-word RAM, and reads it back to verify the write. It replaces the testbench-timed `#`-delay sequencing with a synthesizable start/busy/done FSM. It sits between a host (start/result) and the `rom_16`/`ram_4` pair, driving their address, data and RW lines.

---
 rtl/romram_pkg.sv | 18 +
 rtl/rom_checksum_ctrl_if.sv | 22 ++
 rtl/rom_checksum_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/romram_pkg.sv
// Shared widths, checksum index and FSM state encoding for the ROM checksum sequencer.
package romram_pkg;

  localparam int DATA_W  = 16;
  localparam int ROM_AW  = 4;
  localparam int RAM_AW  = 2;
  localparam int CHK_IDX = (1 << ROM_AW) - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_CHK,
    S_WR,
    S_VFY,
    S_DONE
  } state_t;

endpackage

// File: rtl/rom_checksum_ctrl_if.sv
// Memory-side bus between the checksum sequencer (master) and the ROM/RAM pair (slave).
interface rom_checksum_ctrl_if;
  import romram_pkg::*;

  logic [ROM_AW-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [RAM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_rw;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output rom_addr, ram_addr, ram_wdata, ram_rw,
    input  rom_data, ram_rdata
  );

  modport slave (
    input  rom_addr, ram_addr, ram_wdata, ram_rw,
    output rom_data, ram_rdata
  );

endinterface

// File: rtl/rom_checksum_ctrl.sv
// Walks the ROM, sums words 0..N-2, compares against the checksum word, writes the
// sum into RAM and reads it back, under a start/busy/done handshake.
module rom_checksum_ctrl
  import romram_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [RAM_AW-1:0]   dst_addr,
  rom_checksum_ctrl_if.master mem,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   sum,
  output logic                match,
  output logic                wb_ok
);

  localparam logic [ROM_AW-1:0] LAST_ADD = ROM_AW'(CHK_IDX - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ROM_AW-1:0] r_romAddr;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] r_ramWdata;
  logic [RAM_AW-1:0] r_ramAddr;
  logic              r_ramRw;
  logic              r_busy;
  logic              r_done;
  logic              r_match;
  logic              r_wbOk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ACC;
      S_ACC:   if (r_romAddr == LAST_ADD) w_next = S_CHK;
      S_CHK:   w_next = S_WR;
      S_WR:    w_next = S_VFY;
      S_VFY:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ram_rw and done are raised on the transition into WR/DONE so they are
  // registered and last exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_romAddr  <= '0;
      r_acc      <= '0;
      r_sum      <= '0;
      r_ramWdata <= '0;
      r_ramAddr  <= '0;
      r_ramRw    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_match    <= 1'b0;
      r_wbOk     <= 1'b0;
    end else begin
      r_ramRw <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_romAddr <= '0;
            r_acc     <= '0;
            r_sum     <= '0;
            r_match   <= 1'b0;
            r_wbOk    <= 1'b0;
            r_ramAddr <= dst_addr;
            r_busy    <= 1'b1;
          end
        end
        S_ACC: begin
          r_acc     <= r_acc + mem.rom_data;
          r_romAddr <= r_romAddr + 1'b1;
        end
        S_CHK: begin
          r_match    <= (r_acc == mem.rom_data);
          r_sum      <= r_acc;
          r_ramWdata <= r_acc;
          r_ramRw    <= 1'b1;
        end
        S_VFY: begin
          r_wbOk <= (mem.ram_rdata == r_acc);
          r_done <= 1'b1;
        end
        S_DONE:  r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  assign mem.rom_addr  = r_romAddr;
  assign mem.ram_addr  = r_ramAddr;
  assign mem.ram_wdata = r_ramWdata;
  assign mem.ram_rw    = r_ramRw;
  assign busy          = r_busy;
  assign done          = r_done;
  assign sum           = r_sum;
  assign match         = r_match;
  assign wb_ok         = r_wbOk;

endmodule
